// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SD SPI block reader/writer pair.
// Command frames are 48 bits: command byte, 32-bit argument, CRC byte.
package sd_spi_pkg;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] CMD24       = 8'h58;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] DUMMY_CRC   = 8'hFF;
  localparam int         BLOCK_WORDS = 256;
  localparam int         CMD_BITS    = 48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_R1,
    S_WAIT_TOKEN,
    S_RD_DATA,
    S_RD_CRC,
    S_ERR,
    S_DONE_WAIT
  } sd_rd_state_t;

  function automatic logic [47:0] sd_cmd_frame(input logic [7:0] cmd, input logic [31:0] arg);
    return {cmd, arg, DUMMY_CRC};
  endfunction

endpackage

// File: rtl/sd_miso_deser.sv
// MSB-first MISO deserialiser: 16-bit shift register, bit counter and registered word strobe.
// Used for the R1 byte (caller watches the low byte and count) and for data/CRC words.
module sd_miso_deser
  import sd_spi_pkg::*;
(
  input  logic        clk_25m,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        shift_en_i,
  input  logic        strobe_en_i,
  input  logic        miso_i,
  output logic [7:0]  byte_next_o,
  output logic [3:0]  bit_cnt_o,
  output logic        word_vld_o,
  output logic [15:0] word_o
);

  logic [15:0] sh_q;
  logic [15:0] sh_next;
  logic [3:0]  cnt_q;
  logic        vld_q;
  logic [15:0] word_q;

  assign sh_next     = {sh_q[14:0], miso_i};
  assign byte_next_o = sh_next[7:0];
  assign bit_cnt_o   = cnt_q;
  assign word_vld_o  = vld_q;
  assign word_o      = word_q;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      vld_q <= 1'b0;
      if (clr_i) begin
        sh_q  <= '0;
        cnt_q <= '0;
      end else if (shift_en_i) begin
        sh_q  <= sh_next;
        cnt_q <= cnt_q + 4'd1;
        // Strobe lands in the cycle after the 16th bit is sampled.
        if (strobe_en_i && cnt_q == 4'hF) begin
          vld_q  <= 1'b1;
          word_q <= sh_next;
        end
      end
    end
  end

endmodule

// File: rtl/sd_read_block.sv
// SPI-mode SD single-block reader: issues CMD17, checks R1, waits for the start token,
// then streams 256 x 16-bit words. One shared down-counter times the command, R1, token and done phases.
module sd_read_block
  import sd_spi_pkg::*;
#(
  parameter int R1_TIMEOUT    = 64,
  parameter int TOKEN_TIMEOUT = 100000,
  parameter int DONE_CLKS     = 8
) (
  input  logic        clk_25m,
  input  logic        rst,
  input  logic        init_done,
  input  logic [31:0] sec,
  input  logic        rd_start_en,
  output logic        rd_busy,
  output logic        sd_cs,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        rd_val_en,
  output logic [15:0] rd_val_data,
  output logic        sd_block_rdone,
  output logic        rd_err
);

  localparam int TMR_A   = (R1_TIMEOUT > CMD_BITS) ? R1_TIMEOUT : CMD_BITS;
  localparam int TMR_B   = (TOKEN_TIMEOUT > DONE_CLKS) ? TOKEN_TIMEOUT : DONE_CLKS;
  localparam int TMR_MAX = (TMR_A > TMR_B) ? TMR_A : TMR_B;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  sd_rd_state_t     state_q, state_d;
  logic [47:0]      cmd_q, cmd_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic [7:0]       tok_q, tok_d;
  logic             err_q, err_d;
  logic             tmr_zero;

  logic             des_clr;
  logic             des_shift;
  logic             des_strobe;
  logic [7:0]       des_byte;
  logic [3:0]       des_cnt;

  sd_miso_deser u_deser (
    .clk_25m     (clk_25m),
    .rst         (rst),
    .clr_i       (des_clr),
    .shift_en_i  (des_shift),
    .strobe_en_i (des_strobe),
    .miso_i      (sd_miso),
    .byte_next_o (des_byte),
    .bit_cnt_o   (des_cnt),
    .word_vld_o  (rd_val_en),
    .word_o      (rd_val_data)
  );

  assign tmr_zero = (tmr_q == '0);

  // In WAIT_R1 the deserialiser idles until the first 0 (the R1 start bit) arrives.
  assign des_clr    = !(state_q inside {S_WAIT_R1, S_RD_DATA, S_RD_CRC});
  assign des_shift  = (state_q == S_WAIT_R1) ? (des_cnt != 4'd0 || !sd_miso) : 1'b1;
  assign des_strobe = (state_q == S_RD_DATA);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tmr_d      = tmr_q;
    word_cnt_d = word_cnt_q;
    tok_d      = '0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (rd_start_en && init_done) begin
          state_d    = S_SEND_CMD;
          cmd_d      = sd_cmd_frame(CMD17, sec);
          tmr_d      = TMR_W'(CMD_BITS - 1);
          word_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_SEND_CMD: begin
        cmd_d = {cmd_q[46:0], 1'b1};
        if (tmr_zero) begin
          state_d = S_WAIT_R1;
          tmr_d   = TMR_W'(R1_TIMEOUT - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_WAIT_R1: begin
        if (des_cnt == 4'd7) begin
          if (des_byte == 8'h00) begin
            state_d = S_WAIT_TOKEN;
            tmr_d   = TMR_W'(TOKEN_TIMEOUT - 1);
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else if (des_cnt == 4'd0 && sd_miso) begin
          if (tmr_zero) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end
      S_WAIT_TOKEN: begin
        tok_d = {tok_q[6:0], sd_miso};
        if (tok_d == START_TOKEN) begin
          state_d = S_RD_DATA;
        end else if (tmr_zero) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RD_DATA: begin
        if (des_cnt == 4'hF) begin
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_q == 8'(BLOCK_WORDS - 1)) state_d = S_RD_CRC;
        end
      end
      S_RD_CRC: begin
        if (des_cnt == 4'hF) begin
          state_d = S_DONE_WAIT;
          tmr_d   = TMR_W'(DONE_CLKS - 1);
        end
      end
      S_ERR: begin
        state_d = S_DONE_WAIT;
        tmr_d   = TMR_W'(DONE_CLKS - 1);
      end
      S_DONE_WAIT: begin
        if (tmr_zero) state_d = S_IDLE;
        else          tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '1;
      tmr_q      <= '0;
      word_cnt_q <= '0;
      tok_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tmr_q      <= tmr_d;
      word_cnt_q <= word_cnt_d;
      tok_q      <= tok_d;
      err_q      <= err_d;
    end
  end

  assign rd_busy        = (state_q != S_IDLE);
  assign sd_cs          = (state_q inside {S_IDLE, S_DONE_WAIT});
  assign sd_mosi        = (state_q == S_SEND_CMD) ? cmd_q[47] : 1'b1;
  assign sd_block_rdone = (state_q == S_DONE_WAIT) && tmr_zero && !err_q;
  assign rd_err         = err_q;

endmodule
